ps2_key_decoder: RTL and testbench

Receives PS/2 keyboard frames on the raw keyboard clock/data pins and turns them into the held-key scan code that the game top level compares against its key constants (up, down, enter, esc). It is the producer end of each `i_key_*` bus: one instance per keyboard. Make codes latch the key, break codes release it, and E0/F0 prefixes are absorbed. Framing, parity and stall errors are flagged and the affected byte is discarded.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_frame_rx.sv | 112 +++++++++++
 rtl/ps2_key_decoder.sv | 78 +++++++
 tb/tb_ps2_key_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants and frame FSM state type.
// The game top level imports the key constants from here.
package ps2_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    // A PS/2 frame carries odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM,
// parity/stop checking and a stall timeout. Emits one byte per good frame.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("ps2_frame_rx: SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    rx_state_e       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par;
    logic [TW-1:0]   to_cnt;

    // The bus idles high, so the chains reset to 1 to avoid a false edge at reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous
            // stage's old value, which is what turns these flops into a shift chain.
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
            rx_byte <= '0;
            byte_ok <= 1'b0;
            err     <= 1'b0;
        end else begin
            byte_ok <= 1'b0;
            err     <= 1'b0;

            if (state == S_IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            // err lands on the cycle the count reaches TIMEOUT.
            if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
                state <= S_IDLE;
                err   <= 1'b1;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!data_bit) begin
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par   <= data_bit;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        if (data_bit && odd_parity_ok(shift, par)) begin
                            rx_byte <= shift;
                            byte_ok <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns received PS/2 bytes into a held-key scan code: make latches, break releases,
// E0/F0 prefixes are absorbed into flags for the following code.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_key,
    output logic       o_extended,
    output logic       o_key_valid,
    output logic       o_frame_err
);

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       err;
    logic       ext_flag;
    logic       brk_flag;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) u_rx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .rx_byte    (rx_byte),
        .byte_ok    (byte_ok),
        .err        (err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key       <= '0;
            o_extended  <= 1'b0;
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;

            if (err) begin
                o_frame_err <= 1'b1;
                ext_flag    <= 1'b0;
                brk_flag    <= 1'b0;
            end else if (byte_ok) begin
                case (rx_byte)
                    PFX_EXT: ext_flag <= 1'b1;
                    PFX_BRK: brk_flag <= 1'b1;
                    default: begin
                        if (brk_flag) begin
                            // Only releasing the key actually held clears it.
                            if (rx_byte == o_key && ext_flag == o_extended) begin
                                o_key      <= '0;
                                o_extended <= 1'b0;
                            end
                        end else begin
                            o_key       <= rx_byte;
                            o_extended  <= ext_flag;
                            o_key_valid <= 1'b1;
                        end
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames push expected pulses,
// a monitor pops and compares them whenever o_key_valid or o_frame_err fires.
module tb_ps2_key_decoder;

    localparam int SYNC = 2;
    localparam int TO   = 200;
    localparam int H    = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] o_key;
    logic       o_extended;
    logic       o_key_valid;
    logic       o_frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] key;
        logic       ext;
        bit         lat_chk;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  stop_cyc = 0;

    ps2_key_decoder #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_key       (o_key),
        .o_extended  (o_extended),
        .o_key_valid (o_key_valid),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] key, input logic ext, input bit lat_chk);
        ev_t e;
        e.is_err  = is_err;
        e.key     = key;
        e.ext     = ext;
        e.lat_chk = lat_chk;
        exp_q.push_back(e);
    endtask

    // Sends the first nbits of a frame (11 = full); bad_par flips the parity bit.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b0, 11);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (o_key_valid || o_frame_err)) begin
            check("pulse_excl", {31'd0, o_key_valid & o_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_key_valid, o_frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, o_frame_err}, {31'd0, e.is_err});
                check("pulse_key", {24'd0, o_key}, {24'd0, e.key});
                check("pulse_ext", {31'd0, o_extended}, {31'd0, e.ext});
                if (e.lat_chk) check("latency", cyc - stop_cyc, SYNC + 2);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key", {24'd0, o_key}, 32'h00);
        check("rst_ext", {31'd0, o_extended}, 32'd0);
        check("rst_valid", {31'd0, o_key_valid}, 32'd0);
        check("rst_err", {31'd0, o_frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Plain make
        push(0, 8'h5A, 1'b0, 1);
        send(8'h5A);
        check("make_key", {24'd0, o_key}, 32'h5A);

        // Extended make, then extended break
        send(8'hE0);
        push(0, 8'h75, 1'b1, 1);
        send(8'h75);
        check("ext_make_key", {24'd0, o_key}, 32'h75);
        check("ext_make_ext", {31'd0, o_extended}, 32'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("ext_brk_key", {24'd0, o_key}, 32'h00);
        check("ext_brk_ext", {31'd0, o_extended}, 32'd0);

        // Break of a different key is ignored
        push(0, 8'h72, 1'b0, 1);
        send(8'h72);
        send(8'hF0);
        send(8'h5A);
        check("other_brk_key", {24'd0, o_key}, 32'h72);
        send(8'hF0);
        send(8'h72);
        check("own_brk_key", {24'd0, o_key}, 32'h00);

        // Typematic repeat
        for (int i = 0; i < 3; i++) begin
            push(0, 8'h76, 1'b0, 1);
            send(8'h76);
            check("repeat_key", {24'd0, o_key}, 32'h76);
        end

        // Parity error after an E0 prefix: key held, prefix dropped
        send(8'hE0);
        push(1, 8'h76, 1'b0, 1);
        send_frame(8'h5A, 1'b1, 11);
        check("par_err_key", {24'd0, o_key}, 32'h76);
        push(0, 8'h72, 1'b0, 1);
        send(8'h72);
        check("after_err_ext", {31'd0, o_extended}, 32'd0);

        // Stall mid-frame
        push(1, 8'h72, 1'b0, 0);
        send_frame(8'h5A, 1'b0, 5);
        ps2_data = 1'b1;
        repeat (TO + 10) @(posedge clk);
        #1;
        push(0, 8'h5A, 1'b0, 1);
        send(8'h5A);
        check("after_stall_key", {24'd0, o_key}, 32'h5A);

        // Reset mid-frame
        send_frame(8'h76, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_key", {24'd0, o_key}, 32'h00);
        check("midrst_flags", {30'd0, o_key_valid, o_frame_err}, 32'd0);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push(0, 8'h75, 1'b0, 1);
        send(8'h75);
        check("after_rst_key", {24'd0, o_key}, 32'h75);

        repeat (50) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
